// File: rtl/dc_offset_remover_pkg.sv
// Purpose: shared state encoding and width derivations for the DC offset remover.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dc_offset_pkg;

  // FILL: first block after reset/clr, no valid average yet. RUN: average valid.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } dc_state_e;

  // Sample counter width: log2 of the (power-of-two) averaging window.
  function automatic int unsigned cnt_width(input int unsigned win);
    return (win < 2) ? 1 : $clog2(win);
  endfunction

  // Block sum width: a full block of max-code samples fits exactly.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned win);
    return dw + cnt_width(win);
  endfunction

endpackage

// File: rtl/dc_offset_remover_adc_edge_detect.sv
// Purpose: synchronise adc_clk into clk and emit a 1-clk strobe per rising edge.
// Latency: strobe is high 3 clk after the adc_clk rise is first sampled.
// Backpressure: none; rises within 4 clk of the previous strobe are dropped.
module adc_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_rise;
  logic [1:0] r_holdoff;
  logic       w_edge;

  assign w_edge = r_sync2 & ~r_prev;
  assign o_rise = r_rise;

  // Two-flop synchroniser, edge register, and a holdoff that keeps strobes >= 4 clk apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_rise    <= 1'b0;
      r_holdoff <= 2'd0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge && (r_holdoff == 2'd0)) begin
        r_rise    <= 1'b1;
        r_holdoff <= 2'd3;
      end else begin
        r_rise <= 1'b0;
        if (r_holdoff != 2'd0) begin
          r_holdoff <= r_holdoff - 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dc_offset_remover.sv
// Purpose: block-average DC estimate of an ADC stream and subtract it per sample.
// Latency: data_out/out_stb 1 clk after the internal sample strobe (4 clk after adc_clk rise).
// Backpressure: none; one result per accepted adc_clk edge. Option: DC_OFFSET_REMOVER_ROUND_EN.
module dc_offset_remover
  import dc_offset_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int AVG_WINDOW = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adc_clk,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  clr,
  output logic [DATA_WIDTH:0]   data_out,
  output logic                  out_stb,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] avg_reg
);

  localparam int unsigned CW = cnt_width(AVG_WINDOW);
  localparam int unsigned SW = sum_width(DATA_WIDTH, AVG_WINDOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(AVG_WINDOW - 1);

`ifdef DC_OFFSET_REMOVER_ROUND_EN
  // Round half up: bias by half a window before dropping the fraction.
  localparam logic [SW-1:0] RND = SW'(AVG_WINDOW / 2);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic                  w_stb;
  logic                  w_last;
  logic [SW-1:0]         w_sum_next;
  logic [SW-1:0]         w_block_total;
  logic [DATA_WIDTH-1:0] w_avg_new;
  logic [DATA_WIDTH:0]   w_diff;

  logic [SW-1:0]         r_sum;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_avg;
  logic [DATA_WIDTH:0]   r_data_out;
  logic                  r_out_stb;
  logic                  r_en;
  dc_state_e             r_state;

  adc_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (adc_clk),
    .o_rise (w_stb)
  );

  // A full block of max-code samples plus the rounding bias still fits in SW bits,
  // and the shifted result always fits in DATA_WIDTH bits.
  assign w_last        = (r_cnt == CNT_LAST);
  assign w_sum_next    = r_sum + SW'(adc_data);
  assign w_block_total = w_sum_next + RND;
  assign w_avg_new     = DATA_WIDTH'(w_block_total >> CW);
  // One extra bit makes the unsigned difference an exact signed result.
  assign w_diff        = {1'b0, adc_data} - {1'b0, r_avg};

  assign data_out = r_data_out;
  assign out_stb  = r_out_stb;
  assign en       = r_en;
  assign avg_reg  = r_avg;

  // Output stage: register the DC-removed sample and pulse the strobe once per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_out_stb  <= 1'b0;
    end else begin
      r_out_stb <= w_stb;
      if (w_stb) begin
        r_data_out <= w_diff;
      end
    end
  end

  // Accumulator, block average load and FILL/RUN tracking; clr wins over a coincident sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cnt   <= '0;
      r_avg   <= '0;
      r_en    <= 1'b0;
      r_state <= FILL;
    end else if (clr) begin
      r_sum   <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_state <= FILL;
    end else if (w_stb) begin
      // en follows the state seen by this sample, so it rises with the first
      // output that used a freshly loaded average.
      r_en <= (r_state == RUN);
      if (w_last) begin
        r_avg   <= w_avg_new;
        r_sum   <= '0;
        r_cnt   <= '0;
        r_state <= RUN;
      end else begin
        r_sum <= w_sum_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dc_offset_remover.sv
// Purpose: self-checking bench for dc_offset_remover against a block-average reference model.
// Latency: expects each result 4 clk after the adc_clk rise, one per adc_clk period.
// Backpressure: none exercised; the holdoff on fast adc_clk toggling is checked.
`timescale 1ns/1ps
module tb_dc_offset_remover;

  localparam int DW  = 12;
  localparam int WIN = 1024;
`ifdef DC_OFFSET_REMOVER_ROUND_EN
  localparam int M_RND   = WIN / 2;
  localparam int EXP_ALT = 1001;
`else
  localparam int M_RND   = 0;
  localparam int EXP_ALT = 1000;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          adc_clk  = 1'b0;
  logic          clr      = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [DW:0]   data_out;
  logic          out_stb;
  logic          en;
  logic [DW-1:0] avg_reg;

  always #5 clk = ~clk;

  dc_offset_remover #(.DATA_WIDTH(DW), .AVG_WINDOW(WIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adc_clk  (adc_clk),
    .adc_data (adc_data),
    .clr      (clr),
    .data_out (data_out),
    .out_stb  (out_stb),
    .en       (en),
    .avg_reg  (avg_reg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running block sum, samples in block, average, blocks done since restart.
  int m_sum    = 0;
  int m_n      = 0;
  int m_avg    = 0;
  int m_blocks = 0;
  int m_outs   = 0;

  typedef struct {
    int din;
    int exp_out;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_restart();
    m_sum    = 0;
    m_n      = 0;
    m_blocks = 0;
    m_outs   = 0;
  endtask

  task automatic do_sample(input int v, input int lo, input int hi, input bit clr_at_stb);
    int lat;
    int extra;
    int exp_out;
    int got;
    bit exp_en;
    adc_clk  = 1'b0;
    adc_data = v[DW-1:0];
    repeat (lo) @(negedge clk);
    adc_clk = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (clr) clr = 1'b0;
      if (out_stb || lat >= 12) break;
      if (clr_at_stb && lat == 3) clr = 1'b1;
    end
    exp_out = v - m_avg;
    exp_en  = (m_blocks >= 1) && !clr_at_stb;
    m_outs++;
    if (clr_at_stb) begin
      model_restart();
    end else begin
      m_sum += v;
      m_n++;
      if (m_n == WIN) begin
        m_avg = (m_sum + M_RND) / WIN;
        m_sum = 0;
        m_n   = 0;
        m_blocks++;
      end
    end
    check("stb_latency", lat, 4);
    if (out_stb) begin
      got = $signed(data_out);
      check("data_out", got, exp_out);
      check("en", int'(en), int'(exp_en));
      check("avg_reg", int'(avg_reg), m_avg);
    end
    @(negedge clk);
    check("stb_width", int'(out_stb), 0);
    extra = 0;
    repeat (hi) begin
      @(negedge clk);
      if (out_stb) extra++;
    end
    check("stb_extra", extra, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_en_low", int'(en), 0);
    check("clr_avg_kept", int'(avg_reg), m_avg);
    model_restart();
  endtask

  task automatic apply_reset(input bit do_check);
    adc_clk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (do_check) begin
      check("rst_data_out", int'(data_out), 0);
      check("rst_out_stb", int'(out_stb), 0);
      check("rst_en", int'(en), 0);
      check("rst_avg_reg", int'(avg_reg), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_avg = 0;
    model_restart();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int last_i;
    int min_gap;
    int first_en;
    int nz;
    int got;
    int v;
    bit in_rng;

    tbl[0] = '{din: 0,    exp_out: -4095};
    tbl[1] = '{din: 4095, exp_out: 0};
    tbl[2] = '{din: 1,    exp_out: -4094};
    tbl[3] = '{din: 2048, exp_out: -2047};

    // Reset values.
    #1 apply_reset(1'b1);

    // Holdoff: adc_clk toggling every clk must give strobes exactly 4 clk apart.
    cnt = 0; last_i = -100; min_gap = 1000;
    for (int i = 0; i < 46; i++) begin
      if (i < 40) adc_clk = ~adc_clk; else adc_clk = 1'b0;
      @(negedge clk);
      if (out_stb) begin
        cnt++;
        if (i - last_i < min_gap) min_gap = i - last_i;
        last_i = i;
      end
    end
    in_rng = (cnt >= 9) && (cnt <= 11);
    check("holdoff_count_in_9_11", int'(in_rng), 1);
    check("holdoff_min_gap", min_gap, 4);
    apply_reset(1'b0);

    // Constant 2048: en rises on output 1025, zero residual from then on.
    first_en = 0; nz = 0;
    for (int i = 1; i <= 2048; i++) begin
      do_sample(2048, 4, 0, 1'b0);
      if (en && first_en == 0) first_en = i;
      got = $signed(data_out);
      if (i >= 1025 && got != 0) nz++;
    end
    check("const_first_en_index", first_en, 1025);
    check("const_nonzero_after_avg", nz, 0);
    check("const_avg", int'(avg_reg), 2048);

    // clr in RUN, refill with full-scale, then boundary table against avg=4095.
    pulse_clr();
    for (int i = 1; i <= 1024; i++) do_sample(4095, 4, 0, 1'b0);
    check("refill_en_still_low", int'(en), 0);
    check("refill_avg", int'(avg_reg), 4095);
    for (int k = 0; k < 4; k++) begin
      do_sample(tbl[k].din, 4, 0, 1'b0);
      got = $signed(data_out);
      check("table_data_out", got, tbl[k].exp_out);
      check("table_en", int'(en), 1);
    end

    // Alternating 1000/1001: truncation vs round-half-up.
    pulse_clr();
    for (int i = 0; i < 1024; i++) do_sample(((i % 2) == 0) ? 1000 : 1001, 4, 0, 1'b0);
    check("alt_avg", int'(avg_reg), EXP_ALT);
    do_sample(1000, 4, 0, 1'b0);
    got = $signed(data_out);
    check("alt_next_out", got, 1000 - EXP_ALT);

    // Reset at sample 300 of a block with en high and a non-zero average.
    for (int i = 0; i < 299; i++) do_sample(int'($urandom_range(0, 4095)), 4, 0, 1'b0);
    check("pre_reset_en", int'(en), 1);
    apply_reset(1'b1);
    do_sample(4095, 4, 0, 1'b0);
    got = $signed(data_out);
    check("fill_max_out", got, 4095);
    for (int i = 2; i <= 1024; i++) do_sample(int'($urandom_range(0, 4095)), 4, 0, 1'b0);
    check("post_reset_en_1024", int'(en), 0);
    do_sample(int'($urandom_range(0, 4095)), 4, 0, 1'b0);
    check("post_reset_en_1025", int'(en), 1);

    // Sine around 1500 at a 20-clk adc_clk period.
    pulse_clr();
    for (int i = 0; i < 1024 + 64; i++) begin
      v = int'(500.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0) + 1500.0);
      do_sample(v, 10, 5, 1'b0);
      if (i == 1023) begin
        in_rng = (int'(avg_reg) >= 1499) && (int'(avg_reg) <= 1501);
        check("sine_avg_1500pm1", int'(in_rng), 1);
      end
      if (i >= 1024) begin
        got = $signed(data_out);
        in_rng = (got >= -501) && (got <= 501);
        check("sine_out_range", int'(in_rng), 1);
      end
    end

    // Random samples and periods, with occasional clr landing on the sample strobe.
    for (int i = 0; i < 200; i++) begin
      do_sample(int'($urandom_range(0, 4095)), int'($urandom_range(4, 8)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dc_offset_remover.md
DC_OFFSET_REMOVER -- requirements
Module: dc_offset_remover

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: unsigned ADC sample width.
REQ-002 SHALL have parameter AVG_WINDOW, default 1024: samples per averaging block; power of two, 2..65536.
REQ-003 SHALL have port clk  input  1: system clock (200 MHz).
REQ-004 SHALL have port rst_n  input  1: reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port adc_clk  input  1: ADC sample clock (10 MHz), treated as a data signal in the clk domain; adc_data changes on its falling edge.
REQ-006 SHALL have port adc_data  input  DATA_WIDTH: unsigned ADC code.
REQ-007 SHALL have port clr  input  1: synchronous restart of averaging, 1-clk pulse.
REQ-008 SHALL have port data_out  output  DATA_WIDTH+1: signed, DC-removed sample for the AutoCorr data input.
REQ-009 SHALL have port out_stb  output  1: 1-clk pulse per new data_out.
REQ-010 SHALL have port en  output  1: level; high when data_out is computed against a valid average; drives AutoCorr en.
REQ-011 SHALL have port avg_reg  output  DATA_WIDTH: current DC estimate.

Function
REQ-012 SHALL pass adc_clk through a 2-FF synchronizer plus an edge register and detect its rising edge, producing a 1-clk sample strobe 3 clk after the rising edge.
REQ-013 SHALL capture adc_data on the sample strobe clock.
REQ-014 SHALL register data_out = captured sample − avg_reg (signed, DATA_WIDTH+1, no overflow possible) and pulse out_stb exactly 1 clk after the sample strobe.
REQ-015 SHALL accumulate samples in a sum of width DATA_WIDTH+log2(AVG_WINDOW) and a sample counter of width log2(AVG_WINDOW).
REQ-016 SHALL, on the sample completing a block (counter wraps to 0), load avg_reg = (sum + sample) >> log2(AVG_WINDOW) and clear sum to 0 in the same clk.
REQ-017 SHALL subtract, for the sample completing a block, the old avg_reg; the new average applies from the next sample.
REQ-018 SHALL implement states FILL (first block, en=0) and RUN (en=1); FILL→RUN when the first block completes; RUN stays until reset or clr.
REQ-019 SHALL assert en on the same clk as the first out_stb computed with the first loaded average, and hold en high thereafter.
REQ-020 SHALL emit out_stb and data_out in FILL too (using avg_reg=0), with en low.
REQ-021 SHALL, on clr, clear sum and counter, enter FILL, and drop en next clk; avg_reg is retained; clr coincident with a sample strobe discards that sample from the sum.
REQ-022 SHALL ignore adc_clk edges closer than 4 clk apart (at most one strobe per 4 clk).

Reset
REQ-023 SHALL on rst_n low asynchronously clear synchronizer, sum, counter, avg_reg, data_out, out_stb, en to 0 and state to FILL; reset mid-block discards the partial sum.

Configuration
REQ-024 SHALL, with DC_OFFSET_REMOVER_ROUND_EN defined, add AVG_WINDOW/2 before the shift in REQ-016 (round-half-up); without it, truncate.

Structure
REQ-025 SHALL place the state enum (FILL, RUN) and sum/counter width-derivation constants in package dc_offset_pkg.
REQ-026 SHALL implement the synchronizer and edge detector as sub-module adc_edge_detect (outputs a 1-clk rise strobe).

Verification
REQ-027 SHALL cover: constant adc_data=2048 for 2048 samples → en rises at output 1025, data_out=0 from output 1025 on, avg_reg=2048.
REQ-028 SHALL cover: 500·sin(2πi/256)+1500 → after block 1 avg_reg=1500±1, data_out within [−501,+501], one out_stb per adc_clk period (20 clk).
REQ-029 SHALL cover: alternating 1000/1001 for one block → avg_reg=1001 with DC_OFFSET_REMOVER_ROUND_EN, 1000 without.
REQ-030 SHALL cover: avg_reg=4095 then adc_data=0 → data_out=−4095 (13-bit, no wrap); avg_reg=0 and adc_data=4095 → +4095.
REQ-031 SHALL cover: rst_n low at sample 300 of block 1 → all outputs 0 immediately; after release en rises only after a full 1024 new samples.
REQ-032 SHALL cover: clr pulse in RUN → en low next clk, avg_reg unchanged, en high again after 1024 further samples.
